// File: rtl/switch_defs.sv
// Shared definitions for the switch debouncer: FSM state encodings and
// the default qualification length.
package switch_defs;

    localparam logic [1:0] ST_LO  = 2'd0;
    localparam logic [1:0] CHK_HI = 2'd1;
    localparam logic [1:0] ST_HI  = 2'd2;
    localparam logic [1:0] CHK_LO = 2'd3;

    // Default number of consecutive synchronized cycles a new level must hold.
    localparam int unsigned STABLE_CYCLES_DEFAULT = 32'd50000;

    // True while a candidate transition is being qualified.
    function automatic logic is_check_state(input logic [1:0] st);
        return (st == CHK_HI) || (st == CHK_LO);
    endfunction

endpackage

// File: rtl/switch_sync.sv
// Multi-stage flop synchronizer for a single asynchronous level.
// Reusable for any other asynchronous input that needs bringing into clk.
module switch_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] chain_r;

    // Shift the raw level through the chain; only the last stage is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_r <= {SYNC_STAGES{1'b0}};
        end else begin
            chain_r <= {chain_r[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain_r[SYNC_STAGES-1];

endmodule

// File: rtl/switch_debouncer.sv
// Debounces a raw mechanical switch into a clean synchronous level with
// one-cycle rise/fall strobes and a wrapping count of accepted edges.
// db_out feeds the CMOS inverter stage input directly, so it is registered.
module switch_debouncer
    import switch_defs::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_in,
    output logic       db_out,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic       busy,
    output logic [7:0] edge_count
);

    // Counter value at which the candidate level has been stable long enough.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 32'd1);

    logic                 sync_s;
    logic [1:0]           state_r;
    logic [1:0]           state_nxt_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_nxt_s;
    logic                 db_nxt_s;
    logic                 rise_nxt_s;
    logic                 fall_nxt_s;
    logic [7:0]           edge_nxt_s;

    switch_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (sw_in),
        .sync_out (sync_s)
    );

    // Next-state logic: a level change is accepted only after it survives
    // STABLE_CYCLES qualification cycles; any reversal aborts the candidate.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        db_nxt_s    = db_out;
        rise_nxt_s  = 1'b0;
        fall_nxt_s  = 1'b0;
        edge_nxt_s  = edge_count;
        case (state_r)
            ST_LO: begin
                if (sync_s) begin
                    state_nxt_s = CHK_HI;
                    cnt_nxt_s   = {CNT_WIDTH{1'b0}};
                end else begin
                    state_nxt_s = ST_LO;
                end
            end
            CHK_HI: begin
                if (!sync_s) begin
                    state_nxt_s = ST_LO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_HI;
                    db_nxt_s    = 1'b1;
                    rise_nxt_s  = 1'b1;
                    edge_nxt_s  = edge_count + 8'd1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_WIDTH'(1);
                end
            end
            ST_HI: begin
                if (!sync_s) begin
                    state_nxt_s = CHK_LO;
                    cnt_nxt_s   = {CNT_WIDTH{1'b0}};
                end else begin
                    state_nxt_s = ST_HI;
                end
            end
            CHK_LO: begin
                if (sync_s) begin
                    state_nxt_s = ST_HI;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_LO;
                    db_nxt_s    = 1'b0;
                    fall_nxt_s  = 1'b1;
                    edge_nxt_s  = edge_count + 8'd1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_nxt_s = ST_LO;
                cnt_nxt_s   = {CNT_WIDTH{1'b0}};
                db_nxt_s    = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; reset aborts any qualification.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_LO;
            cnt_r      <= {CNT_WIDTH{1'b0}};
            db_out     <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            edge_count <= 8'd0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            db_out     <= db_nxt_s;
            rise_pulse <= rise_nxt_s;
            fall_pulse <= fall_nxt_s;
            edge_count <= edge_nxt_s;
        end
    end

    assign busy = is_check_state(state_r);

endmodule
